// File: rtl/viterbi_bist.sv
// Built-in self-test engine for a rate-1/2 Viterbi decoder: generates and encodes a
// message, streams it with a zero tail, then scores decoded bits against a replayed copy.
module viterbi_bist #(
    parameter int unsigned  MSG_LEN = 512,
    parameter int unsigned  TBLEN   = 32,
    parameter int unsigned  K       = 3,
    parameter logic [K-1:0] G0      = 3'b111,
    parameter logic [K-1:0] G1      = 3'b101,
    parameter logic [15:0]  SEED    = 16'hACE1,
    parameter int unsigned  CNT_W   = 32,
    parameter int unsigned  TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [15:0]      inj_period,
    output logic             d_in_valid,
    output logic [1:0]       d_in,
    input  logic             d_out_valid,
    input  logic             d_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] correct_cnt,
    output logic [CNT_W-1:0] error_cnt
);
    localparam int unsigned SYM_TOTAL = MSG_LEN + TBLEN;
    localparam int unsigned SYM_W     = $clog2(SYM_TOTAL + 1);
    localparam int unsigned CHK_W     = $clog2(MSG_LEN + 1);
    localparam int unsigned IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [SYM_W-1:0]  SYM_MSG_END = SYM_W'(MSG_LEN);
    localparam logic [SYM_W-1:0]  SYM_END     = SYM_W'(SYM_TOTAL);
    localparam logic [CHK_W-1:0]  CHK_END     = CHK_W'(MSG_LEN);
    localparam logic [IDLE_W-1:0] IDLE_END    = IDLE_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, SEND, FLUSH, DRAIN, DONE} state_t;

    state_t             state, state_n;
    logic [SYM_W-1:0]   sym_cnt, sym_cnt_n;
    logic [CHK_W-1:0]   chk_cnt, chk_cnt_n;
    logic [IDLE_W-1:0]  idle_cnt, idle_cnt_n;
    logic [15:0]        gen_lfsr, gen_lfsr_n, rep_lfsr, rep_lfsr_n;
    logic               gen_phase, gen_phase_n, rep_phase, rep_phase_n;
    logic [K-2:0]       enc_s, enc_s_n;
    logic [1:0]         mode_q, mode_q_n;
    logic [15:0]        inj_period_q, inj_period_q_n, inj_cnt, inj_cnt_n;
    logic               d_in_valid_n, busy_n, done_n, pass_n, timeout_n;
    logic [1:0]         d_in_n;
    logic [CNT_W-1:0]   correct_n, error_n;

    logic               launch, issue, issue_msg, m, inj_hit, chk_hit, rep_bit;
    logic [K-1:0]       enc_reg;
    logic [1:0]         src_mode;
    logic [15:0]        src_lfsr, src_period, src_inj;
    logic               src_phase;
    logic [K-2:0]       src_s;
    logic [SYM_W-1:0]   src_sym;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic msg_bit(input logic [1:0] md, input logic lsb, input logic phase);
        case (md)
            2'd0:    return lsb;
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return phase;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        state_n        = state;
        sym_cnt_n      = sym_cnt;
        chk_cnt_n      = chk_cnt;
        idle_cnt_n     = idle_cnt;
        gen_lfsr_n     = gen_lfsr;
        gen_phase_n    = gen_phase;
        rep_lfsr_n     = rep_lfsr;
        rep_phase_n    = rep_phase;
        enc_s_n        = enc_s;
        mode_q_n       = mode_q;
        inj_period_q_n = inj_period_q;
        inj_cnt_n      = inj_cnt;
        pass_n         = pass;
        timeout_n      = timeout;
        correct_n      = correct_cnt;
        error_n        = error_cnt;
        d_in_valid_n   = 1'b0;
        d_in_n         = 2'b00;
        issue          = 1'b0;
        issue_msg      = 1'b0;
        m              = 1'b0;
        enc_reg        = '0;
        inj_hit        = 1'b0;

        // A launching run takes its first symbol from freshly reloaded sources
        launch     = start && (state == IDLE || state == DONE);
        src_mode   = launch ? mode : mode_q;
        src_lfsr   = launch ? SEED : gen_lfsr;
        src_phase  = launch ? 1'b1 : gen_phase;
        src_s      = launch ? '0 : enc_s;
        src_period = launch ? inj_period : inj_period_q;
        src_inj    = launch ? 16'd0 : inj_cnt;
        src_sym    = launch ? '0 : sym_cnt;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n        = SEND;
                    issue          = 1'b1;
                    issue_msg      = 1'b1;
                    chk_cnt_n      = '0;
                    idle_cnt_n     = '0;
                    correct_n      = '0;
                    error_n        = '0;
                    pass_n         = 1'b0;
                    timeout_n      = 1'b0;
                    rep_lfsr_n     = SEED;
                    rep_phase_n    = 1'b1;
                    mode_q_n       = mode;
                    inj_period_q_n = inj_period;
                end
            end
            SEND: begin
                issue = 1'b1;
                if (sym_cnt < SYM_MSG_END) issue_msg = 1'b1;
                else                       state_n   = FLUSH;
            end
            FLUSH: begin
                if (sym_cnt < SYM_END) issue   = 1'b1;
                else                   state_n = DRAIN;
            end
            DRAIN: begin
                idle_cnt_n = d_out_valid ? '0 : idle_cnt + IDLE_W'(1);
                if (idle_cnt_n == IDLE_END) begin
                    state_n   = DONE;
                    timeout_n = 1'b1;
                    pass_n    = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Encode one symbol; injection flips only the transmitted parity, not the encoder state
        if (issue) begin
            m            = issue_msg ? msg_bit(src_mode, src_lfsr[0], src_phase) : 1'b0;
            enc_reg      = {m, src_s};
            inj_hit      = (src_period != 16'd0) && (16'(src_inj + 16'd1) == src_period);
            d_in_valid_n = 1'b1;
            d_in_n       = {^(enc_reg & G1), (^(enc_reg & G0)) ^ inj_hit};
            enc_s_n      = enc_reg[K-1:1];
            sym_cnt_n    = src_sym + SYM_W'(1);
            inj_cnt_n    = inj_hit ? 16'd0 : 16'(src_inj + 16'd1);
            if (issue_msg) begin
                gen_phase_n = ~src_phase;
                gen_lfsr_n  = (src_mode == 2'd0) ? lfsr_step(src_lfsr) : src_lfsr;
            end
        end

        // Score decoded bits against the replay generator
        rep_bit = msg_bit(mode_q, rep_lfsr[0], rep_phase);
        chk_hit = (state == SEND || state == FLUSH || state == DRAIN) && d_out_valid
                  && (chk_cnt != CHK_END);
        if (chk_hit) begin
            if (d_out == rep_bit) correct_n = sat_inc(correct_cnt);
            else                  error_n   = sat_inc(error_cnt);
            chk_cnt_n   = chk_cnt + CHK_W'(1);
            rep_phase_n = ~rep_phase;
            if (mode_q == 2'd0) rep_lfsr_n = lfsr_step(rep_lfsr);
            if (chk_cnt_n == CHK_END) begin
                state_n      = DONE;
                pass_n       = (error_n == '0);
                timeout_n    = 1'b0;
                d_in_valid_n = 1'b0;
                d_in_n       = 2'b00;
            end
        end

        busy_n = (state_n == SEND) || (state_n == FLUSH) || (state_n == DRAIN);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state        <= IDLE;
            sym_cnt      <= '0;
            chk_cnt      <= '0;
            idle_cnt     <= '0;
            gen_lfsr     <= SEED;
            gen_phase    <= 1'b1;
            rep_lfsr     <= SEED;
            rep_phase    <= 1'b1;
            enc_s        <= '0;
            mode_q       <= 2'd0;
            inj_period_q <= 16'd0;
            inj_cnt      <= 16'd0;
            d_in_valid   <= 1'b0;
            d_in         <= 2'b00;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            correct_cnt  <= '0;
            error_cnt    <= '0;
        end else begin
            state        <= state_n;
            sym_cnt      <= sym_cnt_n;
            chk_cnt      <= chk_cnt_n;
            idle_cnt     <= idle_cnt_n;
            gen_lfsr     <= gen_lfsr_n;
            gen_phase    <= gen_phase_n;
            rep_lfsr     <= rep_lfsr_n;
            rep_phase    <= rep_phase_n;
            enc_s        <= enc_s_n;
            mode_q       <= mode_q_n;
            inj_period_q <= inj_period_q_n;
            inj_cnt      <= inj_cnt_n;
            d_in_valid   <= d_in_valid_n;
            d_in         <= d_in_n;
            busy         <= busy_n;
            done         <= done_n;
            pass         <= pass_n;
            timeout      <= timeout_n;
            correct_cnt  <= correct_n;
            error_cnt    <= error_n;
        end
    end
endmodule
